// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, state encoding and vote helper for the UART blocks
package uart_pkg;

    typedef enum int {
        PARITY_NONE = 0,
        PARITY_EVEN = 1,
        PARITY_ODD  = 2
    } parity_e;

    localparam int         OS_RATE = 16;
    localparam logic [3:0] OS_LAST = 4'(OS_RATE - 1);
    localparam logic [3:0] VOTE_A  = 4'd7;
    localparam logic [3:0] VOTE_B  = 4'd8;
    localparam logic [3:0] VOTE_C  = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAR   = 3'd3,
        ST_STOP  = 3'd4,
        ST_BRK   = 3'd5
    } rx_state_e;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running divider emitting a one-clock oversample tick strobe
module uart_baud_tick #(
    parameter int CLKS_PER_TICK = 326
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int            CW   = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_TICK - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised 16x oversampling UART receiver with valid/ready output
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int CLKS_PER_TICK = 326,
    parameter int DATA_BITS     = 8,
    parameter int PARITY        = 0,
    parameter int STOP_BITS     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 brk,
    output logic                 overrun
);

    localparam bit HAS_PAR = (PARITY != PARITY_NONE);
    localparam bit ODD_PAR = (PARITY == PARITY_ODD);

    logic                 rx_meta_q, rx_s_q;
    logic                 tick;
    rx_state_e            state_q, state_d;
    logic [3:0]           os_q, os_d;
    logic                 samp7_q, samp7_d, samp8_q, samp8_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_acc_q, par_acc_d;
    logic                 frm_acc_q, frm_acc_d;
    logic                 commit_q, commit_d;
    logic                 vote, vote_now, frm_with_vote, load;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 pe_q, pe_d, fe_q, fe_d, brk_q, brk_d;
    logic                 overrun_q, overrun_d;

    uart_baud_tick #(
        .CLKS_PER_TICK(CLKS_PER_TICK)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick_o(tick)
    );

    assign vote          = majority3(samp7_q, samp8_q, rx_s_q);
    assign vote_now      = tick && (os_q == VOTE_C);
    assign frm_with_vote = frm_acc_q | ~vote;

    always_comb begin
        state_d    = state_q;
        os_d       = os_q;
        samp7_d    = samp7_q;
        samp8_d    = samp8_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shreg_d    = shreg_q;
        par_acc_d  = par_acc_q;
        frm_acc_d  = frm_acc_q;
        commit_d   = 1'b0;

        if (tick && (os_q == VOTE_A)) samp7_d = rx_s_q;
        if (tick && (os_q == VOTE_B)) samp8_d = rx_s_q;

        unique case (state_q)
            ST_IDLE: begin
                os_d = '0;
                if (en && !rx_s_q) begin
                    state_d    = ST_START;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    par_acc_d  = 1'b0;
                    frm_acc_d  = 1'b0;
                end
            end
            ST_START: begin
                if (tick) os_d = os_q + 4'd1;
                if (vote_now) state_d = vote ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (tick) os_d = os_q + 4'd1;
                if (vote_now) begin
                    shreg_d   = {vote, shreg_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(DATA_BITS - 1)) state_d = HAS_PAR ? ST_PAR : ST_STOP;
                end
            end
            ST_PAR: begin
                if (tick) os_d = os_q + 4'd1;
                if (vote_now) begin
                    par_acc_d = vote ^ (^shreg_q) ^ ODD_PAR;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (tick) os_d = os_q + 4'd1;
                if (vote_now) begin
                    frm_acc_d  = frm_with_vote;
                    stop_cnt_d = stop_cnt_q + 1'b1;
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        // Leaving at mid-stop leaves half a bit to catch the next start edge.
                        commit_d = 1'b1;
                        os_d     = '0;
                        state_d  = (frm_with_vote && (shreg_q == '0)) ? ST_BRK : ST_IDLE;
                    end
                end
            end
            ST_BRK: begin
                // os counts consecutive high ticks; one full bit of idle ends the break.
                if (tick) begin
                    if (rx_s_q) begin
                        os_d = os_q + 4'd1;
                        if (os_q == OS_LAST) state_d = ST_IDLE;
                    end else begin
                        os_d = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!en) begin
            state_d  = ST_IDLE;
            commit_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            state_q    <= ST_IDLE;
            os_q       <= '0;
            samp7_q    <= 1'b0;
            samp8_q    <= 1'b0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shreg_q    <= '0;
            par_acc_q  <= 1'b0;
            frm_acc_q  <= 1'b0;
            commit_q   <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_s_q     <= rx_meta_q;
            state_q    <= state_d;
            os_q       <= os_d;
            samp7_q    <= samp7_d;
            samp8_q    <= samp8_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shreg_q    <= shreg_d;
            par_acc_q  <= par_acc_d;
            frm_acc_q  <= frm_acc_d;
            commit_q   <= commit_d;
        end
    end

    always_comb begin
        load      = commit_q && (!valid_q || ready);
        valid_d   = load || (valid_q && !ready);
        overrun_d = commit_q && valid_q && !ready;
        data_d    = data_q;
        pe_d      = pe_q;
        fe_d      = fe_q;
        brk_d     = brk_q;
        if (load) begin
            data_d = shreg_q;
            pe_d   = par_acc_q;
            fe_d   = frm_acc_q;
            brk_d  = frm_acc_q && (shreg_q == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            brk_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            pe_q      <= pe_d;
            fe_q      <= fe_d;
            brk_q     <= brk_d;
            overrun_q <= overrun_d;
        end
    end

    assign data       = data_q;
    assign valid      = valid_q;
    assign parity_err = pe_q;
    assign frame_err  = fe_q;
    assign brk        = brk_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - scoreboard bench for uart_rx_param in 8N1, 8E1 and 9N2 builds
module tb_uart_rx_param;

    localparam int CPT      = 4;
    localparam int BIT_CLKS = CPT * 16;

    typedef struct packed {
        logic [8:0] d;
        logic       pe;
        logic       fe;
        logic       bk;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] en_v, rx_v, ready_v;
    logic [7:0] data_a, data_b;
    logic [8:0] data_c;
    logic       valid_a, valid_b, valid_c;
    logic       pe_a, pe_b, pe_c, fe_a, fe_b, fe_c, bk_a, bk_b, bk_c;
    logic       ovr_a, ovr_b, ovr_c;
    logic [2:0] valid_v, pe_v, fe_v, bk_v, ovr_v;
    logic [2:0] valid_prev = '0;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int hs_cnt[3]    = '{default: 0};
    int ovr_cnt[3]   = '{default: 0};
    int rise_cyc[3]  = '{default: 0};
    int start_cyc[3] = '{default: 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    uart_rx_param #(.CLKS_PER_TICK(CPT), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst_n(rst_n), .en(en_v[0]), .rx(rx_v[0]), .data(data_a), .valid(valid_a),
        .ready(ready_v[0]), .parity_err(pe_a), .frame_err(fe_a), .brk(bk_a), .overrun(ovr_a));

    uart_rx_param #(.CLKS_PER_TICK(CPT), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst_n(rst_n), .en(en_v[1]), .rx(rx_v[1]), .data(data_b), .valid(valid_b),
        .ready(ready_v[1]), .parity_err(pe_b), .frame_err(fe_b), .brk(bk_b), .overrun(ovr_b));

    uart_rx_param #(.CLKS_PER_TICK(CPT), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2)) u_9n2 (
        .clk(clk), .rst_n(rst_n), .en(en_v[2]), .rx(rx_v[2]), .data(data_c), .valid(valid_c),
        .ready(ready_v[2]), .parity_err(pe_c), .frame_err(fe_c), .brk(bk_c), .overrun(ovr_c));

    assign valid_v = {valid_c, valid_b, valid_a};
    assign pe_v    = {pe_c, pe_b, pe_a};
    assign fe_v    = {fe_c, fe_b, fe_a};
    assign bk_v    = {bk_c, bk_b, bk_a};
    assign ovr_v   = {ovr_c, ovr_b, ovr_a};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] get_data(input int i);
        case (i)
            0:       return {1'b0, data_a};
            1:       return {1'b0, data_b};
            default: return data_c;
        endcase
    endfunction

    function automatic exp_t mk(input logic [8:0] d_i, input logic pe_i, input logic fe_i, input logic bk_i);
        exp_t e;
        e.d  = d_i;
        e.pe = pe_i;
        e.fe = fe_i;
        e.bk = bk_i;
        return e;
    endfunction

    function automatic int qsize(input int i);
        case (i)
            0:       return q_a.size();
            1:       return q_b.size();
            default: return q_c.size();
        endcase
    endfunction

    task automatic push(input int i, input exp_t e);
        case (i)
            0:       q_a.push_back(e);
            1:       q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
    endtask

    function automatic exp_t pop(input int i);
        case (i)
            0:       return q_a.pop_front();
            1:       return q_b.pop_front();
            default: return q_c.pop_front();
        endcase
    endfunction

    task automatic score(input int i);
        exp_t e;
        logic have;
        have = (qsize(i) != 0);
        check($sformatf("dut%0d_word_expected", i), 32'(have), 32'd1);
        if (have) begin
            e = pop(i);
            check($sformatf("dut%0d_data", i), 32'(get_data(i)), 32'(e.d));
            check($sformatf("dut%0d_parity_err", i), 32'(pe_v[i]), 32'(e.pe));
            check($sformatf("dut%0d_frame_err", i), 32'(fe_v[i]), 32'(e.fe));
            check($sformatf("dut%0d_brk", i), 32'(bk_v[i]), 32'(e.bk));
        end
    endtask

    // Scoreboard side: every accepted word is popped against the queue of its receiver.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (ovr_v[i]) ovr_cnt[i]++;
                if (valid_v[i] && !valid_prev[i]) rise_cyc[i] = cyc;
                if (valid_v[i] && ready_v[i]) begin
                    hs_cnt[i]++;
                    score(i);
                end
            end
        end
        valid_prev = valid_v;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold_bit(input int sel, input logic b);
        rx_v[sel] = b;
        idle(BIT_CLKS);
    endtask

    task automatic send_frame(input int sel, input logic [8:0] d, input int nbits, input logic has_par,
                              input logic pbit, input int nstop, input logic last_stop);
        start_cyc[sel] = cyc;
        hold_bit(sel, 1'b0);
        for (int i = 0; i < nbits; i++) hold_bit(sel, d[i]);
        if (has_par) hold_bit(sel, pbit);
        for (int i = 0; i < nstop; i++) hold_bit(sel, (i == nstop - 1) ? last_stop : 1'b1);
        rx_v[sel] = 1'b1;
    endtask

    task automatic wait_drain(input int sel);
        int n;
        n = 0;
        while (qsize(sel) != 0 && n < 4 * BIT_CLKS) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("dut%0d_drain_pending", sel), 32'(qsize(sel)), 32'd0);
    endtask

    initial begin
        int hs0;
        int ov0;
        int lat;
        rst_n   = 1'b0;
        en_v    = 3'b111;
        rx_v    = 3'b111;
        ready_v = 3'b111;
        repeat (4) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("dut%0d_reset_valid", i), 32'(valid_v[i]), 32'd0);
            check($sformatf("dut%0d_reset_overrun", i), 32'(ovr_v[i]), 32'd0);
            check($sformatf("dut%0d_reset_data", i), 32'(get_data(i)), 32'd0);
            check($sformatf("dut%0d_reset_flags", i), 32'({pe_v[i], fe_v[i], bk_v[i]}), 32'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(BIT_CLKS);

        // 8N1 0xA5 held with ready low, then released
        ready_v[0] = 1'b0;
        push(0, mk(9'h0A5, 1'b0, 1'b0, 1'b0));
        send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1, 1'b1);
        lat = rise_cyc[0] - start_cyc[0];
        check("a5_latency_window", 32'(lat >= 9 * BIT_CLKS && lat <= 10 * BIT_CLKS), 32'd1);
        check("a5_valid_held", 32'(valid_v[0]), 32'd1);
        ready_v[0] = 1'b1;
        idle(1);
        check("a5_valid_cleared", 32'(valid_v[0]), 32'd0);
        wait_drain(0);

        // Glitch of 5 ticks, then a real frame
        hs0 = hs_cnt[0];
        rx_v[0] = 1'b0;
        idle(5 * CPT);
        rx_v[0] = 1'b1;
        idle(2 * BIT_CLKS);
        check("glitch_no_word", 32'(hs_cnt[0] - hs0), 32'd0);
        push(0, mk(9'h05A, 1'b0, 1'b0, 1'b0));
        send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1, 1'b1);
        wait_drain(0);

        // Overrun: second frame arrives while the first is still held
        ready_v[0] = 1'b0;
        hs0 = hs_cnt[0];
        ov0 = ovr_cnt[0];
        push(0, mk(9'h011, 1'b0, 1'b0, 1'b0));
        send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1);
        send_frame(0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1);
        idle(BIT_CLKS);
        check("ovr_pulse_cycles", 32'(ovr_cnt[0] - ov0), 32'd1);
        check("ovr_valid_held", 32'(valid_v[0]), 32'd1);
        ready_v[0] = 1'b1;
        idle(1);
        check("ovr_valid_cleared", 32'(valid_v[0]), 32'd0);
        idle(2 * BIT_CLKS);
        check("ovr_word_count", 32'(hs_cnt[0] - hs0), 32'd1);

        // Break: 20 bit times low yields exactly one break word
        hs0 = hs_cnt[0];
        push(0, mk(9'h000, 1'b0, 1'b1, 1'b1));
        rx_v[0] = 1'b0;
        idle(20 * BIT_CLKS);
        check("brk_word_count", 32'(hs_cnt[0] - hs0), 32'd1);
        rx_v[0] = 1'b1;
        idle(2 * BIT_CLKS);
        push(0, mk(9'h07E, 1'b0, 1'b0, 1'b0));
        send_frame(0, 9'h07E, 8, 1'b0, 1'b0, 1, 1'b1);
        wait_drain(0);

        // Reset mid-DATA of 0xFF
        hs0 = hs_cnt[0];
        fork
            send_frame(0, 9'h0FF, 8, 1'b0, 1'b0, 1, 1'b1);
            begin
                idle(3 * BIT_CLKS);
                rst_n = 1'b0;
                idle(3);
                rst_n = 1'b1;
            end
        join
        idle(BIT_CLKS);
        check("rst_abort_no_word", 32'(hs_cnt[0] - hs0), 32'd0);
        push(0, mk(9'h03C, 1'b0, 1'b0, 1'b0));
        send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b1);
        wait_drain(0);

        // Enable dropped mid-DATA of 0xFF
        hs0 = hs_cnt[0];
        fork
            send_frame(0, 9'h0FF, 8, 1'b0, 1'b0, 1, 1'b1);
            begin
                idle(3 * BIT_CLKS);
                en_v[0] = 1'b0;
                idle(5);
                en_v[0] = 1'b1;
            end
        join
        idle(BIT_CLKS);
        check("en_abort_no_word", 32'(hs_cnt[0] - hs0), 32'd0);
        push(0, mk(9'h03C, 1'b0, 1'b0, 1'b0));
        send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b1);
        wait_drain(0);

        // 8E1: 0x03 has even data parity, so parity bit 1 is wrong and 0 is right
        push(1, mk(9'h003, 1'b1, 1'b0, 1'b0));
        send_frame(1, 9'h003, 8, 1'b1, 1'b1, 1, 1'b1);
        wait_drain(1);
        push(1, mk(9'h003, 1'b0, 1'b0, 1'b0));
        send_frame(1, 9'h003, 8, 1'b1, 1'b0, 1, 1'b1);
        wait_drain(1);

        // 9N2: clean 0x1FF, then 0x1FF with the second stop bit low
        hs0 = hs_cnt[2];
        push(2, mk(9'h1FF, 1'b0, 1'b0, 1'b0));
        send_frame(2, 9'h1FF, 9, 1'b0, 1'b0, 2, 1'b1);
        wait_drain(2);
        push(2, mk(9'h1FF, 1'b0, 1'b1, 1'b0));
        send_frame(2, 9'h1FF, 9, 1'b0, 1'b0, 2, 1'b0);
        wait_drain(2);
        idle(2 * BIT_CLKS);
        check("n2_word_count", 32'(hs_cnt[2] - hs0), 32'd2);

        for (int i = 0; i < 3; i++) begin
            check($sformatf("dut%0d_final_queue", i), 32'(qsize(i)), 32'd0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
- Parametrised successor to the team's fixed 8N1 UART receiver.
- Deserialises an asynchronous serial line into parallel words, with the following added:
  - configurable frame format (data bits, parity, stop bits);
  - 16x oversampling with majority vote;
  - false-start rejection;
  - error and break detection;
  - valid/ready output handshake.
- Sits between the board RX pin and the command/data decoder; runs entirely in the system clock domain using a clock-enable tick, with no derived clocks.

Parameters:
- CLKS_PER_TICK, 326, system clocks per oversample tick (clk_hz / (baud*16)); legal range >= 2.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, 1 or 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  receiver enable.
- rx  in  1  raw serial input, asynchronous, idle high.
- data  out  DATA_BITS  received word, LSB = first bit on the wire.
- valid  out  1  data and flags hold a word.
- ready  in  1  consumer accepts the word when valid && ready.
- parity_err  out  1  parity mismatch on the held word.
- frame_err  out  1  a stop bit sampled low on the held word.
- brk  out  1  held word is a break (all data bits 0, stop bit 0).
- overrun  out  1  one-cycle pulse: a frame was dropped because valid was still high.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0, synchroniser flops 1.
- rx passes through a 2-flop synchroniser (rx_s) before any other use. This adds 2 clk of input latency.
- Tick generator:
  - free-running counter 0..CLKS_PER_TICK-1;
  - tick is a one-cycle strobe when the counter wraps;
  - not gated by en.
- Oversample counter os (0..15) advances on tick. Sample point = majority of rx_s at os = 7, 8, 9; the vote is evaluated at os = 9.
- FSM states: IDLE, START, DATA, PAR, STOP, BRK.
  - IDLE: on rx_s = 0 and en = 1, os := 0 and go to START.
  - START: at the vote, bit = 1 means false start, return to IDLE; bit = 0 goes to DATA.
  - DATA:
    - os wraps at 15, giving one bit per 16 ticks;
    - each vote shifts the bit in LSB-first;
    - after DATA_BITS votes, go to PAR if PARITY != 0, else STOP.
  - PAR: the vote compares against the XOR of the data bits (inverted for odd) and records the mismatch.
  - STOP:
    - vote each stop bit; any 0 records frame_err;
    - after the last stop-bit vote, commit the frame;
    - go to BRK if (data == 0 && frame_err), else IDLE. The early return to IDLE at mid-stop gives a half-bit of resync margin.
  - BRK: wait for rx_s = 1 held for 16 consecutive ticks, then go to IDLE. No further frames are decoded while in BRK.
- Commit (one clk after the final stop vote):
  - if valid = 0 or (valid && ready) in that cycle: load data/parity_err/frame_err/brk and set valid = 1;
  - otherwise: drop the frame, pulse overrun for 1 clk, and leave held outputs untouched.
- Handshake:
  - valid && ready clears valid on the next edge, unless a commit loads the same cycle, in which case valid stays 1 with the new word;
  - data and flags are stable while valid = 1 && ready = 0.
- en = 0: the FSM returns to IDLE on the next clk and any partial frame is discarded. valid and the held word are unaffected and can still be drained.
- rst_n asserted mid-frame: immediate return to the reset state; the partial frame is lost.
- All flags are qualified by valid and meaningless when valid = 0.

Decomposition:
- Shared package uart_pkg holds:
  - PARITY_NONE/EVEN/ODD constants;
  - the FSM state encoding;
  - the OS_RATE = 16 constant and the vote indices 7/8/9.
- One natural sub-module: uart_baud_tick (CLKS_PER_TICK counter emitting the tick strobe), reusable by the planned parametrised transmitter.

Test Plan:
- CLKS_PER_TICK = 4, 8N1: send 0xA5 -> valid after about 9.5 bit times, data = 0xA5, all flags 0; ready = 1 clears valid the next clk.
- 8E1: send 0x03 with parity bit 1 -> parity_err = 1, data = 0x03; with parity bit 0 -> parity_err = 0.
- Glitch: rx low for 5 ticks then high -> no valid, FSM back in IDLE; a following 0x5A is received correctly.
- Hold ready = 0, send 0x11 then 0x22 -> data stays 0x11, one overrun pulse; raise ready -> valid drops, no 0x22 appears.
- Line low for 20 bit times -> one word with data = 0x00, frame_err = 1, brk = 1; the next frame 0x7E is received only after the line has been idle for 16 ticks.
- Deassert rst_n (and separately en) mid-DATA of 0xFF -> no valid; the next frame 0x3C is received intact. DATA_BITS = 9, 2 stop bits: 0x1FF is received, and a low second stop bit -> frame_err = 1.
